// File: rtl/uart_alu_intf_if.sv
// Bundle of UART receive/transmit handshakes and ALU operand/result signals.
// The slave modport is the command stage; the master modport is its environment.
interface uart_alu_intf_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
);
   logic               rx_done_tick;
   logic [NB_DATA-1:0] rx_data;
   logic [NB_DATA-1:0] alu_result;
   logic               tx_done_tick;
   logic [NB_DATA-1:0] alu_data_a;
   logic [NB_DATA-1:0] alu_data_b;
   logic [NB_OP-1:0]   alu_op;
   logic               tx_start;
   logic [NB_DATA-1:0] tx_data;
   logic               busy;

   modport slave (
      input  rx_done_tick,
      input  rx_data,
      input  alu_result,
      input  tx_done_tick,
      output alu_data_a,
      output alu_data_b,
      output alu_op,
      output tx_start,
      output tx_data,
      output busy
   );

   modport master (
      output rx_done_tick,
      output rx_data,
      output alu_result,
      output tx_done_tick,
      input  alu_data_a,
      input  alu_data_b,
      input  alu_op,
      input  tx_start,
      input  tx_data,
      input  busy
   );
endinterface

// File: rtl/uart_alu_intf.sv
// Command/response stage between UART RX, ALU and UART TX: gathers A, B, opcode,
// then transmits the ALU result. Define INTF_TIMEOUT_EN to abandon stalled commands.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  GET_A   | idle, next received byte is operand A
//  GET_B   | waiting for operand B
//  GET_OP  | waiting for opcode byte
//  SEND    | ALU settled on new opcode; latch result, pulse tx_start
//  WAIT_TX | transmission in progress, waiting for tx done edge
module uart_alu_intf #(
   parameter int NB_DATA    = 8,
   parameter int NB_OP      = 6,
   parameter int NB_TIMEOUT = 20,
   parameter int N_TIMEOUT  = 1000000
) (
   input  logic               i_clock,
   input  logic               i_reset,
   uart_alu_intf_if.slave     bus
);

   typedef enum logic [2:0] {
      GET_A   = 3'd0,
      GET_B   = 3'd1,
      GET_OP  = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4
   } state_t;

   state_t             state, state_next;
   logic               rx_d, tx_d;
   logic               rx_ev, tx_ev;
   logic [NB_DATA-1:0] data_a, data_a_next;
   logic [NB_DATA-1:0] data_b, data_b_next;
   logic [NB_OP-1:0]   op, op_next;
   logic [NB_DATA-1:0] tx_data, tx_data_next;
   logic               tx_start, tx_start_next;

`ifdef INTF_TIMEOUT_EN
   localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(N_TIMEOUT - 1);
   logic [NB_TIMEOUT-1:0] to_cnt, to_cnt_next;
`else
   // Timeout parameters have no effect in this build; referenced only to keep them legal.
   if (N_TIMEOUT < 1 || NB_TIMEOUT < 1) begin : g_timeout_unused
   end
`endif

   // Only rising edges of the tick inputs are events; held ticks count once.
   assign rx_ev = bus.rx_done_tick & ~rx_d;
   assign tx_ev = bus.tx_done_tick & ~tx_d;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state    <= GET_A;
         rx_d     <= 1'b1;
         tx_d     <= 1'b1;
         data_a   <= '0;
         data_b   <= '0;
         op       <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
`ifdef INTF_TIMEOUT_EN
         to_cnt   <= '0;
`endif
      end else begin
         state    <= state_next;
         rx_d     <= bus.rx_done_tick;
         tx_d     <= bus.tx_done_tick;
         data_a   <= data_a_next;
         data_b   <= data_b_next;
         op       <= op_next;
         tx_data  <= tx_data_next;
         tx_start <= tx_start_next;
`ifdef INTF_TIMEOUT_EN
         to_cnt   <= to_cnt_next;
`endif
      end
   end

   always_comb begin
      state_next    = state;
      data_a_next   = data_a;
      data_b_next   = data_b;
      op_next       = op;
      tx_data_next  = tx_data;
      tx_start_next = 1'b0;
`ifdef INTF_TIMEOUT_EN
      to_cnt_next   = '0;
`endif
      case (state)
         GET_A: begin
            if (rx_ev) begin
               data_a_next = bus.rx_data;
               state_next  = GET_B;
            end
         end
         GET_B: begin
            if (rx_ev) begin
               data_b_next = bus.rx_data;
               state_next  = GET_OP;
            end
`ifdef INTF_TIMEOUT_EN
            else if (to_cnt == TIMEOUT_LAST) begin
               state_next = GET_A;
            end else begin
               to_cnt_next = to_cnt + 1'b1;
            end
`endif
         end
         GET_OP: begin
            if (rx_ev) begin
               op_next    = bus.rx_data[NB_OP-1:0];
               state_next = SEND;
            end
`ifdef INTF_TIMEOUT_EN
            else if (to_cnt == TIMEOUT_LAST) begin
               state_next = GET_A;
            end else begin
               to_cnt_next = to_cnt + 1'b1;
            end
`endif
         end
         SEND: begin
            // ALU has seen the new opcode for a full cycle by this edge.
            tx_data_next  = bus.alu_result;
            tx_start_next = 1'b1;
            state_next    = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_ev) begin
               state_next = GET_A;
            end
         end
         default: begin
            state_next = GET_A;
         end
      endcase
   end

   assign bus.alu_data_a = data_a;
   assign bus.alu_data_b = data_b;
   assign bus.alu_op     = op;
   assign bus.tx_data    = tx_data;
   assign bus.tx_start   = tx_start;
   assign bus.busy       = (state == SEND) || (state == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf: vector table of full commands plus hand-written
// sequences for held ticks, ignored events, reset abort, pulse timing and timeout.
module tb_uart_alu_intf;
   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
`ifdef INTF_TIMEOUT_EN
   localparam int HOLD = 8;
`else
   localparam int HOLD = 16;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   pulse_cnt = 0;

   uart_alu_intf_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

   uart_alu_intf #(
      .NB_DATA   (NB_DATA),
      .NB_OP     (NB_OP),
      .NB_TIMEOUT(20),
      .N_TIMEOUT (16)
   ) dut (
      .i_clock(clk),
      .i_reset(rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b;
         6'h03:   return 8'($signed(a) >>> b);
         default: return 8'h00;
      endcase
   endfunction

   assign bus.alu_result = alu_model(bus.alu_data_a, bus.alu_data_b, bus.alu_op);

   always @(negedge clk) if (bus.tx_start) pulse_cnt++;

   task automatic check(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(logic [7:0] d, int hold);
      @(posedge clk); #1;
      bus.rx_done_tick = 1'b1;
      bus.rx_data      = d;
      repeat (hold) @(posedge clk);
      #1 bus.rx_done_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_tx_done(int hold);
      @(posedge clk); #1 bus.tx_done_tick = 1'b1;
      repeat (hold) @(posedge clk);
      #1 bus.tx_done_tick = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_cmd(string name, logic [7:0] a, logic [7:0] b, logic [7:0] opb,
                          logic [7:0] exp, int hold);
      int start;
      start = pulse_cnt;
      send_byte(a, hold);
      send_byte(b, hold);
      send_byte(opb, hold);
      for (int i = 0; i < 40 && pulse_cnt == start; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      check({name, " pulses"}, pulse_cnt - start, 1);
      check({name, " tx_data"}, int'(bus.tx_data), int'(exp));
      check({name, " a"}, int'(bus.alu_data_a), int'(a));
      check({name, " b"}, int'(bus.alu_data_b), int'(b));
      check({name, " op"}, int'(bus.alu_op), int'(opb[5:0]));
      check({name, " busy"}, int'(bus.busy), 1);
      send_tx_done(3);
      @(negedge clk);
      check({name, " idle"}, int'(bus.busy), 0);
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int start;
      vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08};
      vecs[1] = '{8'h0A, 8'h02, 8'h22, 8'h08};
      vecs[2] = '{8'hF0, 8'h3C, 8'h24, 8'h30};
      vecs[3] = '{8'hF0, 8'h0F, 8'h25, 8'hFF};
      vecs[4] = '{8'hAA, 8'hFF, 8'h26, 8'h55};
      vecs[5] = '{8'h00, 8'h00, 8'h27, 8'hFF};
      vecs[6] = '{8'h81, 8'h02, 8'h02, 8'h20};
      vecs[7] = '{8'h81, 8'h01, 8'h03, 8'hC0};
      vecs[8] = '{8'hFF, 8'h01, 8'h20, 8'h00};
      vecs[9] = '{8'h07, 8'h08, 8'hE0, 8'h0F};

      rst = 1'b1;
      bus.rx_done_tick = 1'b0;
      bus.rx_data      = '0;
      bus.tx_done_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("reset a", int'(bus.alu_data_a), 0);
      check("reset tx_start", int'(bus.tx_start), 0);
      check("reset busy", int'(bus.busy), 0);
      @(posedge clk); #1 rst = 1'b0;

      // Table: single-cycle ticks, then the same commands with long-held ticks.
      foreach (vecs[i]) run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp, 1);
      for (int i = 0; i < 3; i++) run_cmd($sformatf("hold%0d", i), vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp, HOLD);

      // Extra rx byte during WAIT_TX must be discarded.
      start = pulse_cnt;
      send_byte(8'h05, 1); send_byte(8'h03, 1); send_byte(8'h20, 1);
      repeat (3) @(posedge clk);
      send_byte(8'hFF, 2);
      @(negedge clk);
      check("wait_tx rx a", int'(bus.alu_data_a), 8'h05);
      check("wait_tx rx busy", int'(bus.busy), 1);
      check("wait_tx rx pulses", pulse_cnt - start, 1);
      send_tx_done(2);
      run_cmd("after_discard", 8'h0A, 8'h02, 8'h22, 8'h08, 1);

      // tx done outside WAIT_TX is ignored.
      start = pulse_cnt;
      send_byte(8'h12, 1);
      send_tx_done(3);
      @(negedge clk);
      check("stray tx a", int'(bus.alu_data_a), 8'h12);
      check("stray tx busy", int'(bus.busy), 0);
      send_byte(8'h34, 1); send_byte(8'h20, 1);
      repeat (4) @(negedge clk);
      check("stray tx pulses", pulse_cnt - start, 1);
      check("stray tx data", int'(bus.tx_data), 8'h46);
      send_tx_done(1);

      // Reset mid-command with rx tick held across release.
      send_byte(8'h11, 1);
      @(negedge clk);
      check("pre-reset a", int'(bus.alu_data_a), 8'h11);
      @(posedge clk); #1;
      bus.rx_done_tick = 1'b1; bus.rx_data = 8'h22;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("post-reset a", int'(bus.alu_data_a), 0);
      check("post-reset b", int'(bus.alu_data_b), 0);
      check("post-reset op", int'(bus.alu_op), 0);
      check("post-reset tx_data", int'(bus.tx_data), 0);
      check("post-reset busy", int'(bus.busy), 0);
      @(posedge clk); #1 bus.rx_done_tick = 1'b0;
      run_cmd("after_reset", 8'h33, 8'h44, 8'h20, 8'h77, 1);

      // tx_start timing relative to the opcode capture edge.
      start = pulse_cnt;
      send_byte(8'h20, 1); send_byte(8'h10, 1);
      @(posedge clk); #1 bus.rx_done_tick = 1'b1; bus.rx_data = 8'h22;
      @(posedge clk);
      @(negedge clk);
      check("timing op", int'(bus.alu_op), 8'h22);
      check("timing start e0", int'(bus.tx_start), 0);
      check("timing busy e0", int'(bus.busy), 1);
      @(negedge clk);
      check("timing start e1", int'(bus.tx_start), 1);
      check("timing data e1", int'(bus.tx_data), 8'h10);
      @(negedge clk);
      check("timing start e2", int'(bus.tx_start), 0);
      bus.rx_done_tick = 1'b0;
      repeat (10) @(negedge clk);
      check("timing single pulse", pulse_cnt - start, 1);
      send_tx_done(1);

`ifdef INTF_TIMEOUT_EN
      send_byte(8'h01, 1);
      repeat (20) @(posedge clk);
      run_cmd("timeout", 8'h04, 8'h07, 8'h20, 8'h0B, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
